// File: rtl/fpa_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency FP adder among N_REQ requesters.
//
// Each requester offers an operand pair with a valid/ready handshake. One pair is
// issued to the adder per cycle. A tag pipe follows every issued pair through the
// adder, so each sum comes back marked with the valid bit of the requester that
// owns it.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-high
//   req_valid  per-requester offer
//   req_a      operand A, 32 bits per requester, requester i in [32i+31:32i]
//   req_b      operand B, same packing
//   req_ready  one-hot or zero grant for this cycle
//   fpa_a      registered operand A to the adder
//   fpa_b      registered operand B to the adder
//   fpa_out    adder result, valid ADD_LAT cycles after fpa_a/fpa_b
//   rsp_valid  one-hot or zero; rsp_data belongs to the flagged requester
//   rsp_data   returned sum, raw IEEE-754 bits; holds between responses
//   busy       any operation in flight (issue register or tag pipe)
module fpa_rr_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          fpa_a,
  output logic [31:0]          fpa_b,
  input  logic [31:0]          fpa_out,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  localparam int unsigned PtrW  = $clog2(N_REQ);
  // Stage 0 tracks the issue register, the last stage lines up with fpa_out.
  localparam int unsigned Depth = ADD_LAT + 1;

  logic [PtrW-1:0]  rr_ptr;
  logic             found;
  logic [PtrW-1:0]  grant_id;
  logic [PtrW-1:0]  next_ptr;
  logic [PtrW:0]    scan_sum;
  logic [PtrW-1:0]  scan_idx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  logic [Depth-1:0] tag_vld;
  logic [PtrW-1:0]  tag_id [Depth];

  // Scan req_valid upward from rr_ptr, wrapping modulo N_REQ; first hit wins.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PtrW + 1)'(k);
      if (scan_sum >= (PtrW + 1)'(N_REQ)) begin
        scan_sum = scan_sum - (PtrW + 1)'(N_REQ);
      end
      scan_idx = scan_sum[PtrW-1:0];
      if (!found && req_valid[scan_idx]) begin
        found               = 1'b1;
        grant_id            = scan_idx;
        req_ready[scan_idx] = 1'b1;
      end
    end
  end

  // AND-OR operand mux keyed by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_a = sel_a | (req_a[32*k +: 32] & {32{req_ready[k]}});
      sel_b = sel_b | (req_b[32*k +: 32] & {32{req_ready[k]}});
    end
  end

  assign next_ptr = (grant_id == PtrW'(N_REQ - 1)) ? '0 : grant_id + PtrW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      fpa_a     <= '0;
      fpa_b     <= '0;
      tag_vld   <= '0;
      for (int s = 0; s < Depth; s++) begin
        tag_id[s] <= '0;
      end
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (found) begin
        rr_ptr <= next_ptr;
        fpa_a  <= sel_a;
        fpa_b  <= sel_b;
      end
      // A bubble enters the tag pipe on cycles without a transfer.
      tag_vld[0] <= found;
      tag_id[0]  <= grant_id;
      for (int s = 1; s < Depth; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (tag_vld[Depth-1]) begin
        rsp_valid <= N_REQ'(1) << tag_id[Depth-1];
        rsp_data  <= fpa_out;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = |tag_vld;

endmodule
